// File: rtl/dma_fifo_pkg.sv
// Shared constants and helpers for the DMA lane FIFO.
package dma_fifo_pkg;

    // Transfer direction encoding
    localparam logic DIR_BYTE_IN  = 1'b0;  // byte-in / word-out (SCSI to memory)
    localparam logic DIR_BYTE_OUT = 1'b1;  // word-in / byte-out (memory to SCSI)

    // Default geometry and the widths derived from it
    localparam int DEF_DEPTH = 8;
    localparam int DEF_LANES = 4;
    localparam int DEF_PW    = $clog2(DEF_DEPTH);
    localparam int DEF_CW    = DEF_PW + 1;
    localparam int DEF_BW    = $clog2(DEF_LANES);

    // Bit offset of a byte lane; lane 0 is the most significant byte
    function automatic int lane_lsb(input int lane, input int lanes);
        return 8 * (lanes - 1 - lane);
    endfunction

endpackage

// File: rtl/dma_fifo_occupancy.sv
// Push/pop arbitration, registered occupancy count, status and sticky error flags.
module dma_fifo_occupancy
    import dma_fifo_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    parameter int CW       = $clog2(DEPTH) + 1
)(
    input  logic          CLK,
    input  logic          RST_FIFO_,
    input  logic          i_flush,
    input  logic          i_push_req,
    input  logic          i_pop_req,
    input  logic          i_ovf_evt,
    input  logic          i_udf_evt,
    output logic          o_push_ok,
    output logic          o_pop_ok,
    output logic          o_wr_ok,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_af,
    output logic          o_ae,
    output logic          o_ovf,
    output logic          o_udf
);

    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_udf;

    // A pop needs a committed word before the edge; a same-cycle push cannot rescue it
    assign o_pop_ok  = i_pop_req && (r_count != '0);
    // The slot at the write pointer is free unless full, or full but being popped now
    assign o_wr_ok   = (r_count != CW'(DEPTH)) || o_pop_ok;
    assign o_push_ok = i_push_req && o_wr_ok;

    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_af    = (r_count >= CW'(AF_LEVEL));
    assign o_ae    = (r_count <= CW'(AE_LEVEL));
    assign o_ovf   = r_ovf;
    assign o_udf   = r_udf;

    // Occupancy count follows effective pushes and pops; a push+pop leaves it unchanged
    always_ff @(posedge CLK or negedge RST_FIFO_) begin
        if (!RST_FIFO_)
            r_count <= '0;
        else if (i_flush)
            r_count <= '0;
        else
            r_count <= r_count + CW'(o_push_ok) - CW'(o_pop_ok);
    end

    // Sticky error flags, cleared only by reset or flush
    always_ff @(posedge CLK or negedge RST_FIFO_) begin
        if (!RST_FIFO_) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (i_flush) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= r_ovf || i_ovf_evt || (i_push_req && !o_wr_ok);
            r_udf <= r_udf || i_udf_evt || (i_pop_req && (r_count == '0));
        end
    end

endmodule

// File: rtl/dma_lane_fifo.sv
// Word/byte FIFO between the 32-bit DMA side and the 8-bit SCSI side.
module dma_lane_fifo
    import dma_fifo_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int LANES    = DEF_LANES,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1,
    parameter int PW       = $clog2(DEPTH),
    parameter int BW       = $clog2(LANES),
    parameter int W        = 8 * LANES
)(
    input  logic          CLK,
    input  logic          RST_FIFO_,
    input  logic          FLUSH,
    input  logic          DIR,
    input  logic [W-1:0]  WR_DATA,
    input  logic [LANES-1:0] WR_BE,
    input  logic          WR_COMMIT,
    input  logic [7:0]    BYTE_IN,
    input  logic          BYTE_WR,
    input  logic          BYTE_RD,
    input  logic          RD_POP,
    input  logic          BP_LOAD,
    input  logic [BW-1:0] BP_VAL,
    output logic [W-1:0]  RD_DATA,
    output logic          RD_VALID,
    output logic [7:0]    RD_BYTE,
    output logic [PW:0]   COUNT,
    output logic          FULL,
    output logic          EMPTY,
    output logic          ALMOST_FULL,
    output logic          ALMOST_EMPTY,
    output logic [BW-1:0] BP,
    output logic          BPEQ0,
    output logic          BPEQLAST,
    output logic          OVF,
    output logic          UDF
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [BW-1:0] r_bp;
    logic [W-1:0]  r_rd_data;
    logic          r_rd_valid;

    logic          w_byte_free;
    logic          w_bwr;
    logic          w_brd;
    logic          w_brd_ok;
    logic          w_bwr_ok;
    logic          w_bp_last;
    logic          w_push_req;
    logic          w_pop_req;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic          w_wr_ok;
    logic          w_ovf_evt;
    logic          w_udf_evt;
    logic          w_empty;
    logic [W-1:0]  w_be_mask;
    logic [W-1:0]  w_bwr_mask;
    logic [W-1:0]  w_wr_word;
    logic [W-1:0]  w_rd_shift;

    // Byte ops lose entirely to BP_LOAD or WR_COMMIT in the same cycle
    assign w_byte_free = !BP_LOAD && !WR_COMMIT;
    assign w_bwr       = (DIR == DIR_BYTE_IN)  && BYTE_WR && w_byte_free;
    assign w_brd       = (DIR == DIR_BYTE_OUT) && BYTE_RD && w_byte_free;
    assign w_bp_last   = (r_bp == BW'(LANES - 1));
    assign w_brd_ok    = w_brd && r_rd_valid;
    assign w_bwr_ok    = w_bwr && w_wr_ok;

    assign w_push_req  = WR_COMMIT || (w_bwr && w_bp_last);
    assign w_pop_req   = RD_POP || (w_brd_ok && w_bp_last);
    assign w_ovf_evt   = ((|WR_BE) || w_bwr) && !w_wr_ok;
    assign w_udf_evt   = w_brd && !r_rd_valid;

    dma_fifo_occupancy #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL),
        .CW       (PW + 1)
    ) u_occ (
        .CLK        (CLK),
        .RST_FIFO_  (RST_FIFO_),
        .i_flush    (FLUSH),
        .i_push_req (w_push_req),
        .i_pop_req  (w_pop_req),
        .i_ovf_evt  (w_ovf_evt),
        .i_udf_evt  (w_udf_evt),
        .o_push_ok  (w_push_ok),
        .o_pop_ok   (w_pop_ok),
        .o_wr_ok    (w_wr_ok),
        .o_count    (COUNT),
        .o_full     (FULL),
        .o_empty    (w_empty),
        .o_af       (ALMOST_FULL),
        .o_ae       (ALMOST_EMPTY),
        .o_ovf      (OVF),
        .o_udf      (UDF)
    );

    // Per-lane write masks; the byte write takes precedence over WR_BE on its lane
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_be_mask[lane_lsb(l, LANES) +: 8]  = {8{WR_BE[l]}};
        assign w_bwr_mask[lane_lsb(l, LANES) +: 8] = {8{w_bwr_ok && (r_bp == BW'(l))}};
    end

    assign w_wr_word = (r_mem[r_wr_ptr] & ~w_be_mask & ~w_bwr_mask)
                     | (WR_DATA & w_be_mask & ~w_bwr_mask)
                     | ({LANES{BYTE_IN}} & w_bwr_mask);

    // Storage: merge lane writes into the slot at the write pointer when it is free
    always_ff @(posedge CLK or negedge RST_FIFO_) begin
        if (!RST_FIFO_) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (!FLUSH && w_wr_ok) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

    // Word pointers advance on effective push/pop and wrap mod DEPTH
    always_ff @(posedge CLK or negedge RST_FIFO_) begin
        if (!RST_FIFO_) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (FLUSH) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push_ok);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop_ok);
        end
    end

    // Byte pointer: load beats commit-clear beats byte-op increment
    always_ff @(posedge CLK or negedge RST_FIFO_) begin
        if (!RST_FIFO_)
            r_bp <= '0;
        else if (FLUSH)
            r_bp <= '0;
        else if (BP_LOAD)
            r_bp <= BP_VAL;
        else if (WR_COMMIT)
            r_bp <= '0;
        else if (w_bwr_ok || w_brd_ok)
            r_bp <= r_bp + 1'b1;
    end

    // Head register: one-cycle bubble after any pop, held across FLUSH
    always_ff @(posedge CLK or negedge RST_FIFO_) begin
        if (!RST_FIFO_) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (!FLUSH)
                r_rd_data <= r_mem[r_rd_ptr];
            r_rd_valid <= !w_empty && !w_pop_ok && !FLUSH;
        end
    end

    assign w_rd_shift = r_rd_data << {r_bp, 3'b000};

    assign RD_DATA  = r_rd_data;
    assign RD_VALID = r_rd_valid;
    assign RD_BYTE  = w_rd_shift[W-1 -: 8];
    assign EMPTY    = w_empty;
    assign BP       = r_bp;
    assign BPEQ0    = (r_bp == '0);
    assign BPEQLAST = w_bp_last;

endmodule

// File: tb/tb_dma_lane_fifo.sv
// Directed plus randomized bench for dma_lane_fifo against a circular-buffer reference.
module tb_dma_lane_fifo;

    logic        CLK = 1'b0;
    logic        RST_FIFO_ = 1'b0;
    logic        t_flush = 0, t_dir = 0, t_commit = 0, t_bwr = 0, t_brd = 0;
    logic        t_pop = 0, t_bpld = 0;
    logic [31:0] t_wdata = 0;
    logic [3:0]  t_be = 0;
    logic [7:0]  t_bin = 0;
    logic [1:0]  t_bpval = 0;

    logic [31:0] RD_DATA;
    logic        RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, BPEQ0, BPEQLAST, OVF, UDF;
    logic [7:0]  RD_BYTE;
    logic [3:0]  COUNT;
    logic [1:0]  BP;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [31:0] m_mem [8];
    int          m_cnt, m_wr, m_rd, m_bp;
    logic [31:0] m_rd_data;
    logic        m_rv, m_ovf, m_udf;
    logic [31:0] saved;

    always #5 CLK = ~CLK;

    dma_lane_fifo dut (
        .CLK(CLK), .RST_FIFO_(RST_FIFO_), .FLUSH(t_flush), .DIR(t_dir),
        .WR_DATA(t_wdata), .WR_BE(t_be), .WR_COMMIT(t_commit), .BYTE_IN(t_bin),
        .BYTE_WR(t_bwr), .BYTE_RD(t_brd), .RD_POP(t_pop), .BP_LOAD(t_bpld), .BP_VAL(t_bpval),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_BYTE(RD_BYTE), .COUNT(COUNT),
        .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
        .BP(BP), .BPEQ0(BPEQ0), .BPEQLAST(BPEQLAST), .OVF(OVF), .UDF(UDF)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        m_cnt = 0; m_wr = 0; m_rd = 0; m_bp = 0;
        m_rd_data = '0; m_rv = 0; m_ovf = 0; m_udf = 0;
    endtask

    // One edge of behaviour, computed from the transfer rules on the inputs now applied
    task automatic model_step();
        logic free, bwr, brd, brd_ok, last, pop_req, pop, push_req, push, room;
        if (t_flush) begin
            m_cnt = 0; m_wr = 0; m_rd = 0; m_bp = 0;
            m_ovf = 0; m_udf = 0; m_rv = 0;
            return;
        end
        free     = !t_bpld && !t_commit;
        bwr      = !t_dir && t_bwr && free;
        brd      = t_dir && t_brd && free;
        last     = (m_bp == 3);
        brd_ok   = brd && m_rv;
        pop_req  = t_pop || (brd_ok && last);
        pop      = pop_req && (m_cnt > 0);
        room     = (m_cnt < 8) || pop;
        push_req = t_commit || (bwr && last);
        push     = push_req && room;
        if ((push_req && !room) || (((t_be != 0) || bwr) && !room)) m_ovf = 1;
        if ((pop_req && m_cnt == 0) || (brd && !m_rv)) m_udf = 1;
        m_rd_data = m_mem[m_rd];
        m_rv      = (m_cnt > 0) && !pop;
        if (room) begin
            for (int l = 0; l < 4; l++)
                if (t_be[l]) m_mem[m_wr][31-8*l -: 8] = t_wdata[31-8*l -: 8];
            if (bwr) m_mem[m_wr][31-8*m_bp -: 8] = t_bin;
        end
        if (t_bpld)                    m_bp = int'(t_bpval);
        else if (t_commit)             m_bp = 0;
        else if ((bwr && room) || brd_ok) m_bp = (m_bp + 1) % 4;
        m_wr  = (m_wr + int'(push)) % 8;
        m_rd  = (m_rd + int'(pop)) % 8;
        m_cnt = m_cnt + int'(push) - int'(pop);
    endtask

    task automatic check_all();
        chk("COUNT",    32'(COUNT),        32'(m_cnt));
        chk("FULL",     32'(FULL),         32'(m_cnt == 8));
        chk("EMPTY",    32'(EMPTY),        32'(m_cnt == 0));
        chk("AFULL",    32'(ALMOST_FULL),  32'(m_cnt >= 6));
        chk("AEMPTY",   32'(ALMOST_EMPTY), 32'(m_cnt <= 1));
        chk("BP",       32'(BP),           32'(m_bp));
        chk("BPEQ0",    32'(BPEQ0),        32'(m_bp == 0));
        chk("BPEQLAST", 32'(BPEQLAST),     32'(m_bp == 3));
        chk("OVF",      32'(OVF),          32'(m_ovf));
        chk("UDF",      32'(UDF),          32'(m_udf));
        chk("RD_VALID", 32'(RD_VALID),     32'(m_rv));
        chk("RD_DATA",  RD_DATA,           m_rd_data);
        chk("RD_BYTE",  32'(RD_BYTE),      32'(m_rd_data[31-8*m_bp -: 8]));
    endtask

    task automatic clr();
        t_flush = 0; t_commit = 0; t_bwr = 0; t_brd = 0; t_pop = 0; t_bpld = 0;
        t_be = 0; t_wdata = 0; t_bin = 0; t_bpval = 0;
    endtask

    task automatic cyc();
        model_step();
        @(posedge CLK);
        #1;
        check_all();
        clr();
    endtask

    task automatic push_word(input logic [31:0] d);
        t_be = 4'hF; t_wdata = d; t_commit = 1; cyc();
    endtask

    initial begin
        logic [7:0] exp_b [4];
        model_reset();
        #12 RST_FIFO_ = 1'b1;
        #1;
        check_all();

        // partial word via bytes then commit; BP_LOAD beats a byte write
        t_dir = 0;
        t_bwr = 1; t_bin = 8'hAA; cyc();
        t_bwr = 1; t_bin = 8'hBB; cyc();
        t_bwr = 1; t_bin = 8'hCC; cyc();
        t_commit = 1; cyc();
        chk("partial_bp0", 32'(BP), 32'd0);
        cyc();
        chk("partial_word", RD_DATA, 32'hAABBCC00);
        t_bpld = 1; t_bpval = 2; t_bwr = 1; t_bin = 8'h55; cyc();
        chk("bpload_bp", 32'(BP), 32'd2);
        chk("bpload_cnt", 32'(COUNT), 32'd1);
        t_flush = 1; cyc();

        // byte-in / word-out: two words assembled from eight bytes
        for (int i = 1; i <= 8; i++) begin
            t_bwr = 1; t_bin = 8'(8'h11 * i); cyc();
        end
        chk("b2w_cnt2", 32'(COUNT), 32'd2);
        chk("b2w_head0", RD_DATA, 32'h11223344);
        t_pop = 1; cyc();
        chk("b2w_cnt1", 32'(COUNT), 32'd1);
        cyc();
        chk("b2w_head1", RD_DATA, 32'h55667788);
        t_pop = 1; cyc();
        chk("b2w_cnt0", 32'(COUNT), 32'd0);

        // word-in / byte-out
        t_dir = 1;
        push_word(32'hDEADBEEF);
        for (int i = 0; i < 8 && !RD_VALID; i++) cyc();
        chk("w2b_rv_wait", 32'(RD_VALID), 32'd1);
        exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
        for (int i = 0; i < 4; i++) begin
            chk("w2b_byte", 32'(RD_BYTE), 32'(exp_b[i]));
            t_brd = 1; cyc();
        end
        chk("w2b_empty", 32'(EMPTY), 32'd1);

        // fill to full, push+pop at full, then overflow
        t_dir = 0;
        for (int i = 0; i < 8; i++) begin
            push_word(32'h1000 + i);
            if (i == 4) chk("af_at5", 32'(ALMOST_FULL), 32'd0);
            if (i == 5) chk("af_at6", 32'(ALMOST_FULL), 32'd1);
        end
        chk("full", 32'(FULL), 32'd1);
        t_be = 4'hF; t_wdata = 32'h2000; t_commit = 1; t_pop = 1; cyc();
        chk("full_pushpop_cnt", 32'(COUNT), 32'd8);
        chk("full_pushpop_ovf", 32'(OVF), 32'd0);
        push_word(32'h3000);
        chk("ovf_set", 32'(OVF), 32'd1);
        chk("ovf_cnt", 32'(COUNT), 32'd8);
        saved = m_rd_data;
        t_flush = 1; cyc();
        chk("flush_cnt", 32'(COUNT), 32'd0);
        chk("flush_ovf", 32'(OVF), 32'd0);
        chk("flush_rd_data", RD_DATA, saved);

        // underflow cases
        t_dir = 1;
        t_brd = 1; cyc();
        chk("brd_udf", 32'(UDF), 32'd1);
        chk("brd_bp", 32'(BP), 32'd0);
        t_flush = 1; cyc();
        t_pop = 1; t_commit = 1; cyc();
        chk("pop_empty_udf", 32'(UDF), 32'd1);
        chk("pop_empty_cnt", 32'(COUNT), 32'd1);

        // randomized phases, direction changed only across a flush
        for (int ph = 0; ph < 4; ph++) begin
            t_flush = 1; cyc();
            t_dir = ph[0];
            for (int n = 0; n < 200; n++) begin
                t_flush  = ($urandom_range(0, 99) == 0);
                t_commit = ($urandom_range(0, 5) == 0);
                t_be     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                t_wdata  = $urandom;
                t_bwr    = ($urandom_range(0, 1) == 0);
                t_brd    = ($urandom_range(0, 1) == 0);
                t_bin    = 8'($urandom);
                t_pop    = ($urandom_range(0, 4 + 2*ph) == 0);
                t_bpld   = ($urandom_range(0, 15) == 0);
                t_bpval  = 2'($urandom);
                cyc();
            end
        end

        // asynchronous reset in the middle of a packet
        t_flush = 1; cyc();
        t_dir = 0;
        for (int i = 0; i < 5; i++) push_word(32'h4000 + i);
        t_bwr = 1; t_bin = 8'h99; cyc();
        t_bwr = 1; t_bin = 8'h9A; cyc();
        chk("pre_rst_cnt", 32'(COUNT), 32'd5);
        #3 RST_FIFO_ = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 RST_FIFO_ = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
